multi_ch_run_ctrl: RTL and testbench

Parametrised multi-channel run-status controller. It is the successor to the single-channel idle/run/done status register, with NUM_CH independent channels. Each channel runs an explicit IDLE/RUN/DONE/ERR state machine with a start/done/clear handshake, a per-channel run-cycle counter and a programmable timeout. It sits between the top-level control register block and NUM_CH datapath engines, and reports per-channel and aggregate status.

---
 rtl/multi_ch_run_ctrl.sv | 69 ++++++
 tb/tb_multi_ch_run_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_run_ctrl.sv
// multi_ch_run_ctrl: per-channel IDLE/RUN/DONE/ERR run controllers with cycle counters, timeout and aggregate status
module multi_ch_run_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter bit AUTO_CLR = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       done_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [CNT_W-1:0]        timeout_i,
  output logic [NUM_CH-1:0]       idle_o,
  output logic [NUM_CH-1:0]       run_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       err_o,
  output logic [NUM_CH*CNT_W-1:0] cycles_o,
  output logic                    busy_o,
  output logic                    all_done_o,
  output logic                    err_any_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, inc;
    logic [CNT_W:0] nxt;
    logic tmo;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        st  <= st_nx;
        cnt <= cnt_nx;
      end
    always_comb begin
      nxt    = {1'b0, cnt} + (CNT_W+1)'(1);
      inc    = nxt[CNT_W] ? cnt : nxt[CNT_W-1:0];
      tmo    = timeout_i != '0 && nxt == {1'b0, timeout_i};
      st_nx  = st;
      cnt_nx = cnt;
      case (st)
        IDLE: if (start_i[c]) begin
          st_nx  = RUN;
          cnt_nx = '0;
        end
        RUN: if (clr_i[c]) st_nx = IDLE;
        else begin
          st_nx  = done_i[c] ? DONE : tmo ? ERR : RUN;
          cnt_nx = inc;
        end
        DONE: if (start_i[c]) begin
          st_nx  = RUN;
          cnt_nx = '0;
        end else if (AUTO_CLR || clr_i[c]) st_nx = IDLE;
        ERR: if (clr_i[c]) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
    assign idle_o[c] = st == IDLE;
    assign run_o[c]  = st == RUN;
    assign done_o[c] = st == DONE;
    assign err_o[c]  = st == ERR;
    assign cycles_o[c*CNT_W +: CNT_W] = cnt;
  end
  assign busy_o     = |run_o;
  assign all_done_o = &done_o;
  assign err_any_o  = |err_o;
endmodule

// File: tb/tb_multi_ch_run_ctrl.sv
// tb_multi_ch_run_ctrl: randomized and directed check of two controller builds against a behavioural model
module tb_multi_ch_run_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] start = '0, done = '0, clr = '0;
  logic [15:0] to_a = '0;
  logic [3:0] to_b = '0;
  logic [3:0] idle_a, run_a, done_a, err_a, idle_b, run_b, done_b, err_b;
  logic [63:0] cyc_a;
  logic [15:0] cyc_b;
  logic busy_a, alld_a, erra_a, busy_b, alld_b, erra_b;
  int tests = 0, fails = 0;
  int m[2][4], c[2][4];
  always #5 clk = ~clk;
  multi_ch_run_ctrl #(.NUM_CH(4), .CNT_W(16), .AUTO_CLR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .clr_i(clr), .timeout_i(to_a),
    .idle_o(idle_a), .run_o(run_a), .done_o(done_a), .err_o(err_a), .cycles_o(cyc_a),
    .busy_o(busy_a), .all_done_o(alld_a), .err_any_o(erra_a));
  multi_ch_run_ctrl #(.NUM_CH(4), .CNT_W(4), .AUTO_CLR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .clr_i(clr), .timeout_i(to_b),
    .idle_o(idle_b), .run_o(run_b), .done_o(done_b), .err_o(err_b), .cycles_o(cyc_b),
    .busy_o(busy_b), .all_done_o(alld_b), .err_any_o(erra_b));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void mstep(input int mo, input int co, input bit s, input bit d, input bit cl,
                                input int lim, input int maxv, input bit auto_c,
                                output int mn, output int cn);
    int up;
    up = co + 1 > maxv ? maxv : co + 1;
    mn = mo;
    cn = co;
    if (mo == 0) begin
      if (s) begin mn = 1; cn = 0; end
    end else if (mo == 1) begin
      if (cl) mn = 0;
      else if (d) begin mn = 2; cn = up; end
      else if (lim != 0 && co + 1 == lim) begin mn = 3; cn = lim; end
      else cn = up;
    end else if (mo == 2) begin
      if (s) begin mn = 1; cn = 0; end
      else if (auto_c || cl) mn = 0;
    end else if (cl) mn = 0;
  endfunction
  task automatic mreset();
    for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) begin m[d][k] = 0; c[d][k] = 0; end
  endtask
  task automatic mstep_all();
    int mn, cn;
    for (int k = 0; k < 4; k++) begin
      mstep(m[0][k], c[0][k], start[k], done[k], clr[k], int'(to_a), 65535, 1'b0, mn, cn);
      m[0][k] = mn; c[0][k] = cn;
      mstep(m[1][k], c[1][k], start[k], done[k], clr[k], int'(to_b), 15, 1'b1, mn, cn);
      m[1][k] = mn; c[1][k] = cn;
    end
  endtask
  task automatic check_all();
    logic [3:0] ei, er, ed, ee;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        ei[k] = m[d][k] == 0; er[k] = m[d][k] == 1; ed[k] = m[d][k] == 2; ee[k] = m[d][k] == 3;
        if (d == 0) chk($sformatf("a_cycles%0d", k), 64'(cyc_a[k*16 +: 16]), 64'(c[0][k]));
        else chk($sformatf("b_cycles%0d", k), 64'(cyc_b[k*4 +: 4]), 64'(c[1][k]));
      end
      chk(d ? "b_idle" : "a_idle", 64'(d ? idle_b : idle_a), 64'(ei));
      chk(d ? "b_run" : "a_run", 64'(d ? run_b : run_a), 64'(er));
      chk(d ? "b_done" : "a_done", 64'(d ? done_b : done_a), 64'(ed));
      chk(d ? "b_err" : "a_err", 64'(d ? err_b : err_a), 64'(ee));
      chk(d ? "b_busy" : "a_busy", 64'(d ? busy_b : busy_a), 64'(|er));
      chk(d ? "b_all_done" : "a_all_done", 64'(d ? alld_b : alld_a), 64'(&ed));
      chk(d ? "b_err_any" : "a_err_any", 64'(d ? erra_b : erra_a), 64'(|ee));
    end
  endtask
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      mstep_all();
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_idle", 64'(idle_a), 64'hF);
    chk("rst_busy", 64'(busy_a), 64'h0);
    chk("rst_all_done", 64'(alld_a), 64'h0);
    check_all();
    rst_n = 1'b1;
    start = 4'b0001;
    cycle();
    start = '0;
    cycle(4);
    chk("t1_run_before_done", 64'(run_a[0]), 64'h1);
    done = 4'b0001;
    cycle();
    done = '0;
    chk("t1_done", 64'(done_a[0]), 64'h1);
    chk("t1_cycles", 64'(cyc_a[15:0]), 64'd5);
    chk("t1_busy_fell", 64'(busy_a), 64'h0);
    chk("t1_auto_done", 64'(done_b[0]), 64'h1);
    cycle();
    chk("t1_auto_idle", 64'(idle_b[0]), 64'h1);
    to_a = 16'd8;
    to_b = 4'd8;
    start = 4'b0010;
    cycle();
    start = '0;
    cycle(7);
    chk("t2_not_yet_err", 64'(err_a[1]), 64'h0);
    cycle();
    chk("t2_err", 64'(err_a[1]), 64'h1);
    chk("t2_err_any", 64'(erra_a), 64'h1);
    chk("t2_cycles", 64'(cyc_a[31:16]), 64'd8);
    start = 4'b0010;
    cycle();
    start = '0;
    chk("t2_sticky", 64'(err_a[1]), 64'h1);
    clr = 4'b0010;
    cycle();
    clr = '0;
    chk("t2_clr_idle", 64'(idle_a[1]), 64'h1);
    start = 4'b0100;
    cycle();
    start = '0;
    cycle(2);
    done = 4'b0100;
    clr = 4'b0100;
    cycle();
    done = '0;
    clr = '0;
    chk("t3_abort_idle", 64'(idle_a[2]), 64'h1);
    chk("t3_abort_cnt_held", 64'(cyc_a[47:32]), 64'd2);
    start = 4'b0100;
    cycle();
    start = '0;
    cycle(7);
    done = 4'b0100;
    cycle();
    done = '0;
    chk("t3_done_at_limit", 64'(done_a[2]), 64'h1);
    chk("t3_cycles", 64'(cyc_a[47:32]), 64'd8);
    to_a = '0;
    to_b = '0;
    clr = 4'hF;
    cycle();
    clr = '0;
    start = 4'hF;
    cycle();
    start = '0;
    for (int k = 0; k < 4; k++) begin
      cycle(2);
      done = 4'(1 << k);
      cycle();
      done = '0;
      chk($sformatf("t4_all_done_%0d", k), 64'(alld_a), 64'(k == 3));
    end
    start = 4'b0001;
    cycle();
    start = '0;
    chk("t4_restart_run", 64'(run_a[0]), 64'h1);
    chk("t4_restart_cnt", 64'(cyc_a[15:0]), 64'd0);
    chk("t4_all_done_drop", 64'(alld_a), 64'h0);
    start = 4'b1000;
    cycle();
    start = '0;
    cycle(20);
    chk("t5_saturate", 64'(cyc_b[15:12]), 64'd15);
    chk("t5_no_err", 64'(err_b), 64'h0);
    chk("t5_a_cnt", 64'(cyc_a[63:48]), 64'd20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_idle", 64'(idle_a), 64'hF);
    chk("t6_cycles", cyc_a, 64'h0);
    chk("t6_busy", 64'(busy_a), 64'h0);
    mreset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) begin
        to_a = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(2, 14));
        to_b = 4'($urandom_range(0, 15));
      end
      for (int k = 0; k < 4; k++) begin
        start[k] = $urandom_range(0, 3) == 0;
        done[k]  = $urandom_range(0, 6) == 0;
        clr[k]   = $urandom_range(0, 9) == 0;
      end
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
